// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-style RAM burst block: the command encoding
// and default sizing constants.
package spi_ram_pkg;

  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_MEM_DEPTH  = 256;

  // Two-bit command carried in the top bits of din.
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port word array with a synchronous write and no reset.
// One address port is shared by writes and reads. The read value is
// combinational, and the caller registers it. A write at one edge is
// therefore visible to a read issued at the following edge.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];

  // Storage update: contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/spi_ram_burst.sv
// Command-driven RAM front end. It holds a write pointer and a read pointer,
// each with an "armed" flag, decodes 2-bit commands from din, and returns
// read data through a registered dout/tx_valid pair. seq_err pulses one cycle
// after an unarmed data command or an out-of-range address.
//
// Handshake: a command is consumed on every rising edge where rx_valid is
// high. There is no back-pressure. tx_valid and seq_err are single-cycle
// pulses that appear on the cycle after the consuming edge.
//
// Optional: define SPI_RAM_AUTOINC_EN to post-increment the relevant pointer
// after each accepted data command. The pointer wraps from MEM_DEPTH-1 to 0.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  seq_err
);

  localparam logic [WORD_WIDTH:0]   DEPTH_W   = (WORD_WIDTH+1)'(MEM_DEPTH);
  localparam logic [WORD_WIDTH-1:0] LAST_ADDR = WORD_WIDTH'(MEM_DEPTH - 1);

  cmd_e                  cmd;
  logic [WORD_WIDTH-1:0] payload;
  logic [WORD_WIDTH-1:0] wr_ptr;
  logic [WORD_WIDTH-1:0] rd_ptr;
  logic                  wr_armed;
  logic                  rd_armed;
  logic                  addr_ok;
  logic                  wr_addr_ok;
  logic                  rd_addr_ok;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  err_next;
  logic [WORD_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_rdata;

  assign cmd     = cmd_e'(din[WORD_WIDTH+1:WORD_WIDTH]);
  assign payload = din[WORD_WIDTH-1:0];
  assign addr_ok = {1'b0, payload} < DEPTH_W;

`ifdef SPI_RAM_AUTOINC_EN
  // Burst mode: step to the next word and wrap at the top of the array.
  function automatic logic [WORD_WIDTH-1:0] next_ptr(input logic [WORD_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction
`else
  // Fixed-address mode: repeated data commands reuse the same word.
  function automatic logic [WORD_WIDTH-1:0] next_ptr(input logic [WORD_WIDTH-1:0] p);
    return p;
  endfunction
`endif

  // Command decode: classify the current command and detect sequence errors.
  always_comb begin
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    wr_addr_ok = 1'b0;
    rd_addr_ok = 1'b0;
    err_next   = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_addr_ok = addr_ok;
          err_next   = !addr_ok;
        end
        CMD_RD_ADDR: begin
          rd_addr_ok = addr_ok;
          err_next   = !addr_ok;
        end
        CMD_WR_DATA: begin
          wr_fire  = wr_armed;
          err_next = !wr_armed;
        end
        CMD_RD_DATA: begin
          rd_fire  = rd_armed;
          err_next = !rd_armed;
        end
        default: ;
      endcase
    end
  end

  // The single memory port serves the write pointer on a write and the read pointer otherwise.
  assign mem_addr = wr_fire ? wr_ptr : rd_ptr;

  spi_ram_mem #(
    .WORD_WIDTH (WORD_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .addr  (mem_addr),
    .wdata (payload),
    .rdata (mem_rdata)
  );

  // Pointer and flag state: address commands load and arm, data commands may advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
    end else begin
      if (wr_addr_ok) begin
        wr_ptr   <= payload;
        wr_armed <= 1'b1;
      end else if (wr_fire) begin
        wr_ptr   <= next_ptr(wr_ptr);
      end
      if (rd_addr_ok) begin
        rd_ptr   <= payload;
        rd_armed <= 1'b1;
      end else if (rd_fire) begin
        rd_ptr   <= next_ptr(rd_ptr);
      end
    end
  end

  // Output registers: dout holds between reads, and the status flags pulse for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      tx_valid <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      tx_valid <= rd_fire;
      seq_err  <= err_next;
      if (rd_fire) dout <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed, table-driven bench for spi_ram_burst.
// The main instance uses the default size (256 words). A second instance with
// 200 words exercises the address range check.
// Vectors that depend on SPI_RAM_AUTOINC_EN are selected with the same macro.
module tb_spi_ram_burst;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W+1:0] din;
  logic         rx_valid;
  logic [W-1:0] dout;
  logic         tx_valid;
  logic         seq_err;

  logic [W+1:0] r_din;
  logic         r_rx_valid;
  logic [W-1:0] r_dout;
  logic         r_tx_valid;
  logic         r_seq_err;

  int tests;
  int fails;

  typedef struct {
    string      name;
    logic       is_rst;
    logic       valid;
    logic [1:0] cmd;
    logic [7:0] payload;
    logic       exp_tx;
    logic       exp_err;
    logic       chk_dout;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t main_v[$];
  vec_t range_v[$];

  spi_ram_burst #(.WORD_WIDTH(W), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .seq_err(seq_err)
  );

  spi_ram_burst #(.WORD_WIDTH(W), .MEM_DEPTH(200)) dut_r (
    .clk(clk), .rst(rst), .din(r_din), .rx_valid(r_rx_valid),
    .dout(r_dout), .tx_valid(r_tx_valid), .seq_err(r_seq_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t cv(string n, logic [1:0] c, logic [7:0] p,
                              logic etx, logic eerr, logic cd, logic [7:0] ed);
    vec_t v;
    v.name = n; v.is_rst = 1'b0; v.valid = 1'b1; v.cmd = c; v.payload = p;
    v.exp_tx = etx; v.exp_err = eerr; v.chk_dout = cd; v.exp_dout = ed;
    return v;
  endfunction

  function automatic vec_t rv(string n);
    vec_t v;
    v = cv(n, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
    v.is_rst = 1'b1; v.valid = 1'b0;
    return v;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic sample_check(input bit which, input vec_t v);
    logic [7:0] d;
    logic       t;
    logic       e;
    d = which ? r_dout     : dout;
    t = which ? r_tx_valid : tx_valid;
    e = which ? r_seq_err  : seq_err;
    check({v.name, ".tx_valid"}, 32'(t), 32'(v.exp_tx));
    check({v.name, ".seq_err"},  32'(e), 32'(v.exp_err));
    if (v.chk_dout) check({v.name, ".dout"}, 32'(d), 32'(v.exp_dout));
  endtask

  // Driver: apply one vector at a falling edge, then check just after the next rising edge.
  task automatic run_vec(input bit which, input vec_t v);
    @(negedge clk);
    if (v.is_rst) begin
      rst = 1'b1; rx_valid = 1'b0; r_rx_valid = 1'b0;
    end else if (which) begin
      r_din = {v.cmd, v.payload}; r_rx_valid = v.valid; rx_valid = 1'b0;
    end else begin
      din = {v.cmd, v.payload}; rx_valid = v.valid; r_rx_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    sample_check(which, v);
    if (v.is_rst) begin
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; din = '0; rx_valid = 1'b0; r_din = '0; r_rx_valid = 1'b0;

    // Range-check instance (200 words): 0xC8 is out of range and 0xC7 is the top word.
    range_v.push_back(cv("r_wa05",   2'b00, 8'h05, 0, 0, 1, 8'h00));
    range_v.push_back(cv("r_wdAB",   2'b01, 8'hAB, 0, 0, 1, 8'h00));
    range_v.push_back(cv("r_ra05",   2'b10, 8'h05, 0, 0, 1, 8'h00));
    range_v.push_back(cv("r_raC8",   2'b10, 8'hC8, 0, 1, 1, 8'h00));
    range_v.push_back(cv("r_rd_old", 2'b11, 8'h00, 1, 0, 1, 8'hAB));
    range_v.push_back(cv("r_waC8",   2'b00, 8'hC8, 0, 1, 1, 8'hAB));
    range_v.push_back(cv("r_wdCD",   2'b01, 8'hCD, 0, 0, 1, 8'hAB));
    range_v.push_back(cv("r_rdCD",   2'b11, 8'h00, 1, 0, 1, 8'hCD));
    range_v.push_back(cv("r_waC7",   2'b00, 8'hC7, 0, 0, 1, 8'hCD));
    range_v.push_back(cv("r_wdEE",   2'b01, 8'hEE, 0, 0, 1, 8'hCD));
    range_v.push_back(cv("r_raC7",   2'b10, 8'hC7, 0, 0, 1, 8'hCD));
    range_v.push_back(cv("r_rdEE",   2'b11, 8'h00, 1, 0, 1, 8'hEE));
    range_v.push_back(cv("r_raFF",   2'b10, 8'hFF, 0, 1, 1, 8'hEE));

    // Main instance: reset state, unarmed commands, basic and back-to-back reads.
    main_v.push_back(rv("reset0"));
    main_v.push_back(cv("rd_unarmed",  2'b11, 8'h00, 0, 1, 1, 8'h00));
    main_v.push_back(cv("wa00",        2'b00, 8'h00, 0, 0, 1, 8'h00));
    main_v.push_back(cv("wd77",        2'b01, 8'h77, 0, 0, 1, 8'h00));
    main_v.push_back(cv("ra00",        2'b10, 8'h00, 0, 0, 1, 8'h00));
    main_v.push_back(cv("rd77",        2'b11, 8'h00, 1, 0, 1, 8'h77));
    main_v.push_back(cv("idle_pulse",  2'b00, 8'h00, 0, 0, 1, 8'h77));
    main_v.push_back(rv("reset1"));
    main_v.push_back(cv("rd_unarm2",   2'b11, 8'h5A, 0, 1, 1, 8'h00));
    main_v.push_back(cv("wd_unarm",    2'b01, 8'h11, 0, 1, 1, 8'h00));
    main_v.push_back(cv("ra00b",       2'b10, 8'h00, 0, 0, 1, 8'h00));
    main_v.push_back(cv("mem0_kept",   2'b11, 8'h00, 1, 0, 1, 8'h77));
    main_v.push_back(cv("wa3C",        2'b00, 8'h3C, 0, 0, 1, 8'h77));
    main_v.push_back(cv("wdA5",        2'b01, 8'hA5, 0, 0, 1, 8'h77));
    main_v.push_back(cv("ra3C",        2'b10, 8'h3C, 0, 0, 1, 8'h77));
    main_v.push_back(cv("rdA5",        2'b11, 8'hFF, 1, 0, 1, 8'hA5));
    main_v.push_back(cv("wa40",        2'b00, 8'h40, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("ra40",        2'b10, 8'h40, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("wdC3",        2'b01, 8'hC3, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("wbr_C3",      2'b11, 8'h00, 1, 0, 1, 8'hC3));
`ifdef SPI_RAM_AUTOINC_EN
    main_v.push_back(cv("b_waFE",      2'b00, 8'hFE, 0, 0, 1, 8'hC3));
    main_v.push_back(cv("b_wd01",      2'b01, 8'h01, 0, 0, 1, 8'hC3));
    main_v.push_back(cv("b_wd02",      2'b01, 8'h02, 0, 0, 1, 8'hC3));
    main_v.push_back(cv("b_wd03",      2'b01, 8'h03, 0, 0, 1, 8'hC3));
    main_v.push_back(cv("b_raFE",      2'b10, 8'hFE, 0, 0, 1, 8'hC3));
    main_v.push_back(cv("b_rd1",       2'b11, 8'h00, 1, 0, 1, 8'h01));
    main_v.push_back(cv("b_rd2",       2'b11, 8'h00, 1, 0, 1, 8'h02));
    main_v.push_back(cv("b_rd3",       2'b11, 8'h00, 1, 0, 1, 8'h03));
`else
    main_v.push_back(cv("b2b_A5a",     2'b10, 8'h3C, 0, 0, 1, 8'hC3));
    main_v.push_back(cv("b2b_A5b",     2'b11, 8'h00, 1, 0, 1, 8'hA5));
    main_v.push_back(cv("b2b_A5c",     2'b11, 8'h12, 1, 0, 1, 8'hA5));
    main_v.push_back(cv("wa11",        2'b00, 8'h11, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("wd22",        2'b01, 8'h22, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("wa10",        2'b00, 8'h10, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("wd55",        2'b01, 8'h55, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("wd66",        2'b01, 8'h66, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("ra10",        2'b10, 8'h10, 0, 0, 1, 8'hA5));
    main_v.push_back(cv("rd66",        2'b11, 8'h00, 1, 0, 1, 8'h66));
    main_v.push_back(cv("ra11",        2'b10, 8'h11, 0, 0, 1, 8'h66));
    main_v.push_back(cv("rd22_kept",   2'b11, 8'h00, 1, 0, 1, 8'h22));
    begin
      vec_t iv;
      iv = cv("ignored_wd", 2'b01, 8'hEE, 0, 0, 1, 8'h22);
      iv.valid = 1'b0;
      main_v.push_back(iv);
    end
    main_v.push_back(cv("rd22_again",  2'b11, 8'h00, 1, 0, 1, 8'h22));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_dout",     32'(dout),     32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_seq_err",  32'(seq_err),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (range_v[i]) run_vec(1'b1, range_v[i]);
    foreach (main_v[i])  run_vec(1'b0, main_v[i]);

    // Reset asserted while a read is being presented: the read must not complete.
    run_vec(1'b0, cv("pre_ra3C", 2'b10, 8'h3C, 0, 0, 1, 8'h22 ^ 8'h22 ^ main_v[main_v.size()-1].exp_dout));
    run_vec(1'b0, cv("pre_rdA5", 2'b11, 8'h00, 1, 0, 1, 8'hA5));
    @(negedge clk);
    din = {2'b11, 8'h00}; rx_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async_dout",     32'(dout),     32'h0);
    check("async_tx_valid", 32'(tx_valid), 32'h0);
    @(posedge clk);
    #1;
    check("rstedge_tx_valid", 32'(tx_valid), 32'h0);
    check("rstedge_dout",     32'(dout),     32'h0);
    check("rstedge_seq_err",  32'(seq_err),  32'h0);
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    run_vec(1'b0, cv("post_rst_rd", 2'b11, 8'h00, 0, 1, 1, 8'h00));
    run_vec(1'b0, cv("post_rst_wd", 2'b01, 8'h42, 0, 1, 1, 8'h00));
    run_vec(1'b0, cv("post_rst_ok", 2'b10, 8'h3C, 0, 0, 1, 8'h00));
    run_vec(1'b0, cv("post_rst_A5", 2'b11, 8'h00, 1, 0, 1, 8'hA5));

    @(negedge clk);
    rx_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
